// File: rtl/onboard_pkg.sv
// Shared types and constants for the board-level boundary-scan wrapper:
// TAP state encoding, register widths, IR opcodes and the arithmetic core.
package onboard_pkg;

    localparam int IR_W   = 4;
    localparam int BSR_W  = 9;
    localparam int CORE_W = 4;

    // Instruction opcodes; any code not listed here behaves as BYPASS
    localparam logic [IR_W-1:0] BYPASS         = 4'b1111;
    localparam logic [IR_W-1:0] SAMPLE_PRELOAD = 4'b0001;
    localparam logic [IR_W-1:0] EXTEST         = 4'b0010;

    // Fixed value loaded into the IR shift stage in CAPTURE_IR
    localparam logic [IR_W-1:0] IR_CAPTURE     = 4'b0001;

    // TAP controller states, using the customary 1149.1 encodings
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    // Combinational core: op=1 adds, op=0 multiplies; both yield 4 bits
    function automatic logic [CORE_W-1:0] core_result(
        input logic [1:0] a,
        input logic [1:0] b,
        input logic       op
    );
        logic [CORE_W-1:0] a_ext;
        logic [CORE_W-1:0] b_ext;
        a_ext = {2'b00, a};
        b_ext = {2'b00, b};
        if (op) begin
            return a_ext + b_ext;
        end
        return a_ext * b_ext;
    endfunction

endpackage

// File: rtl/tap_controller.sv
// 16-state TAP controller. State advances on rising TCK; the strobes are
// plain decodes of the current state so the data registers can act on the
// same rising edge (capture/shift) or the following falling edge (update).
module tap_controller
    import onboard_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_e state,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr
);

    tap_state_e state_q;
    tap_state_e state_d;

    // State register; TRST_N forces TEST_LOGIC_RESET immediately
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard TMS-driven transitions
    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    assign state      = state_q;
    assign capture_ir = (state_q == CAPTURE_IR);
    assign shift_ir   = (state_q == SHIFT_IR);
    assign update_ir  = (state_q == UPDATE_IR);
    assign capture_dr = (state_q == CAPTURE_DR);
    assign shift_dr   = (state_q == SHIFT_DR);
    assign update_dr  = (state_q == UPDATE_DR);

endmodule

// File: rtl/onboard_top.sv
// Board top: 2-bit arithmetic core on the switches, result on LED[15:12],
// wrapped by a 9-cell boundary-scan register driven from the JB header TAP.
// Under EXTEST the LED result pins come from the BSR update latches.
module onboard_top
    import onboard_pkg::*;
(
    input  logic        JB_TCK,
    input  logic        JB_TRST_N,
    input  logic        JB_TMS,
    input  logic        JB_TDI,
    output logic        JB_TDO,
    input  logic [15:0] SW,
    output logic [15:0] LED
);

    tap_state_e        tap_state;
    logic              capture_ir;
    logic              shift_ir;
    logic              update_ir;
    logic              capture_dr;
    logic              shift_dr;
    logic              update_dr;

    logic [IR_W-1:0]   ir_sh_q;
    logic [IR_W-1:0]   ir_sh_d;
    logic [IR_W-1:0]   ir_q;
    logic [IR_W-1:0]   ir_d;
    logic [BSR_W-1:0]  bsr_sh_q;
    logic [BSR_W-1:0]  bsr_sh_d;
    logic [BSR_W-1:0]  bsr_upd_q;
    logic [BSR_W-1:0]  bsr_upd_d;
    logic              byp_q;
    logic              byp_d;
    logic              tdo_q;
    logic              tdo_d;

    logic [CORE_W-1:0] core_res;
    logic [CORE_W-1:0] from_BSR_to_SYS;
    logic              bsr_sel;
    logic              extest_act;
    logic              unused_sw;

    tap_controller u_tap (
        .tck        (JB_TCK),
        .trst_n     (JB_TRST_N),
        .tms        (JB_TMS),
        .state      (tap_state),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr)
    );

    // Core always sees the live switches; there is no INTEST path
    assign core_res  = core_result(SW[15:14], SW[13:12], SW[11]);
    assign unused_sw = ^SW[10:0];

    // Instruction decode: only SAMPLE_PRELOAD and EXTEST select the BSR
    assign extest_act = (ir_q == EXTEST);
    assign bsr_sel    = (ir_q == SAMPLE_PRELOAD) || extest_act;

    // Result mux onto the LEDs
    assign from_BSR_to_SYS = extest_act ? bsr_upd_q[CORE_W-1:0] : core_res;
    assign LED             = {from_BSR_to_SYS, 12'h000};
    assign JB_TDO          = tdo_q;

    // Rising-edge next values: capture and shift for IR, BSR and bypass
    always_comb begin
        ir_sh_d  = ir_sh_q;
        bsr_sh_d = bsr_sh_q;
        byp_d    = byp_q;
        if (capture_ir) begin
            ir_sh_d = IR_CAPTURE;
        end else if (shift_ir) begin
            ir_sh_d = {JB_TDI, ir_sh_q[IR_W-1:1]};
        end
        if (bsr_sel) begin
            if (capture_dr) begin
                bsr_sh_d = {SW[15:11], core_res};
            end else if (shift_dr) begin
                bsr_sh_d = {JB_TDI, bsr_sh_q[BSR_W-1:1]};
            end
        end else begin
            if (capture_dr) begin
                byp_d = 1'b0;
            end else if (shift_dr) begin
                byp_d = JB_TDI;
            end
        end
    end

    // Shift stages; reset discards any partial shift
    always_ff @(posedge JB_TCK or negedge JB_TRST_N) begin
        if (!JB_TRST_N) begin
            ir_sh_q  <= IR_CAPTURE;
            bsr_sh_q <= '0;
            byp_q    <= 1'b0;
        end else begin
            ir_sh_q  <= ir_sh_d;
            bsr_sh_q <= bsr_sh_d;
            byp_q    <= byp_d;
        end
    end

    // Falling-edge next values: IR/BSR update latches and TDO
    always_comb begin
        ir_d      = ir_q;
        bsr_upd_d = bsr_upd_q;
        tdo_d     = 1'b0;
        if (tap_state == TEST_LOGIC_RESET) begin
            ir_d = BYPASS;
        end else if (update_ir) begin
            ir_d = ir_sh_q;
        end
        if (update_dr && bsr_sel) begin
            bsr_upd_d = bsr_sh_q;
        end
        if (shift_ir) begin
            tdo_d = ir_sh_q[0];
        end else if (shift_dr) begin
            tdo_d = bsr_sel ? bsr_sh_q[0] : byp_q;
        end
    end

    // Update latches and TDO change on falling TCK
    always_ff @(negedge JB_TCK or negedge JB_TRST_N) begin
        if (!JB_TRST_N) begin
            ir_q      <= BYPASS;
            bsr_upd_q <= '0;
            tdo_q     <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            bsr_upd_q <= bsr_upd_d;
            tdo_q     <= tdo_d;
        end
    end

endmodule

// File: tb/tb_onboard_top.sv
// Bench for onboard_top: drives the TAP through IR/DR scans, predicts TDO
// streams into a scoreboard queue and checks LEDs, IR and BSR latches.
module tb_onboard_top;
    import onboard_pkg::*;

    logic        JB_TCK = 1'b0;
    logic        JB_TRST_N;
    logic        JB_TMS;
    logic        JB_TDI;
    logic        JB_TDO;
    logic [15:0] SW;
    logic [15:0] LED;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    onboard_top dut (
        .JB_TCK    (JB_TCK),
        .JB_TRST_N (JB_TRST_N),
        .JB_TMS    (JB_TMS),
        .JB_TDI    (JB_TDI),
        .JB_TDO    (JB_TDO),
        .SW        (SW),
        .LED       (LED)
    );

    always #5 JB_TCK = ~JB_TCK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference core, written independently of the RTL package
    function automatic logic [3:0] ref_core(input logic [15:0] sw);
        int a;
        int b;
        int r;
        a = int'(sw[15:14]);
        b = int'(sw[13:12]);
        r = sw[11] ? (a + b) : (a * b);
        return r[3:0];
    endfunction

    function automatic logic [15:0] ref_led(input logic [15:0] sw);
        return {ref_core(sw), 12'h000};
    endfunction

    task automatic sb_push(input string tag, input logic v);
        tag_q.push_back(tag);
        exp_q.push_back(16'(v));
    endtask

    task automatic push_bits(input string tag, input logic [8:0] v, input int n);
        for (int i = 0; i < n; i++) sb_push(tag, v[i]);
    endtask

    // TDO is one scoreboard output; pop and compare each sample
    task automatic sb_pop_tdo();
        if (exp_q.size() == 0) begin
            chk("sb_empty", 16'(exp_q.size()), 16'd1);
        end else begin
            chk(tag_q.pop_front(), 16'(JB_TDO), exp_q.pop_front());
        end
    endtask

    // One TCK: inputs applied mid-low-phase, returns 1 unit after falling edge
    task automatic tick(input logic tms, input logic tdi);
        JB_TMS = tms;
        JB_TDI = tdi;
        @(negedge JB_TCK);
        #1;
    endtask

    // From RUN_TEST_IDLE: load IR (code[0] shifted first), end in RUN_TEST_IDLE
    task automatic load_ir(input logic [3:0] code, input logic [15:0] exp_led);
        push_bits("ir_cap", 9'(IR_CAPTURE), 4);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        sb_pop_tdo();
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, code[i]);
            if (i < 3) sb_pop_tdo();
        end
        tick(1'b1, 1'b0);
        chk("ir_upd", 16'(dut.ir_q), 16'(code));
        chk("led_after_ir", LED, exp_led);
        tick(1'b0, 1'b0);
    endtask

    // From RUN_TEST_IDLE: n-bit DR scan (bits[0] first), end in RUN_TEST_IDLE
    task automatic scan_dr(input int n, input logic [8:0] bits);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        sb_pop_tdo();
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, bits[i]);
            if (i < n - 1) sb_pop_tdo();
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        logic [8:0] byp_in;
        logic [8:0] byp_exp;
        logic [8:0] dr_pat;

        JB_TRST_N = 1'b1;
        JB_TMS    = 1'b1;
        JB_TDI    = 1'b0;
        SW        = 16'b1001_1000_0000_0000;
        #1 JB_TRST_N = 1'b0;
        #1;
        chk("rst_state", 16'(dut.u_tap.state_q), 16'(TEST_LOGIC_RESET));
        chk("rst_ir", 16'(dut.ir_q), 16'(BYPASS));
        chk("rst_tdo", 16'(JB_TDO), 16'd0);
        chk("rst_bsr_upd", 16'(dut.bsr_upd_q), 16'd0);
        chk("rst_led", LED, 16'h3000);

        @(negedge JB_TCK);
        #1 JB_TRST_N = 1'b1;
        tick(1'b0, 1'b0);
        chk("rti_state", 16'(dut.u_tap.state_q), 16'(RUN_TEST_IDLE));
        chk("led_idle", LED, ref_led(SW));

        // SAMPLE_PRELOAD, then preload BSR with 1,0,0,1,0,1,1,1,0
        load_ir(4'b0001, 16'h3000);
        push_bits("bsr_cap_a", {SW[15:11], ref_core(SW)}, 9);
        dr_pat = 9'b011101001;
        scan_dr(9, dr_pat);
        chk("bsr_upd_preload", 16'(dut.bsr_upd_q), 16'(dr_pat));
        chk("led_sample", LED, 16'h3000);

        // EXTEST: LEDs switch to preloaded result cells
        load_ir(4'b0010, 16'h9000);
        chk("from_bsr", 16'(dut.from_BSR_to_SYS), 16'h0009);
        SW = 16'hF000;
        #1;
        chk("led_extest_hold", LED, 16'h9000);

        // Five TMS=1 clocks return to TEST_LOGIC_RESET with IR=BYPASS
        SW = 16'hE800;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("tlr_state", 16'(dut.u_tap.state_q), 16'(TEST_LOGIC_RESET));
        chk("tlr_ir", 16'(dut.ir_q), 16'(BYPASS));
        chk("tlr_led", LED, ref_led(SW));
        chk("tlr_bsr_hold", 16'(dut.bsr_upd_q), 16'(dr_pat));
        tick(1'b0, 1'b0);

        // BYPASS: TDO echoes TDI one clock later, 0 first
        load_ir(4'b1111, ref_led(SW));
        byp_in = 9'b0_0000_1101;
        byp_exp = {byp_in[7:0], 1'b0};
        push_bits("bypass", byp_exp, 5);
        scan_dr(5, byp_in);
        chk("bypass_bsr_hold", 16'(dut.bsr_upd_q), 16'(dr_pat));

        // Unknown opcode behaves as BYPASS
        load_ir(4'b0101, ref_led(SW));
        byp_in = 9'b0_0000_0011;
        byp_exp = {byp_in[7:0], 1'b0};
        push_bits("bypass_unk", byp_exp, 3);
        scan_dr(3, byp_in);

        // SAMPLE capture with A=3, B=3, op=0
        SW = 16'hF000;
        load_ir(4'b0001, ref_led(SW));
        push_bits("sample_cap", {SW[15:11], ref_core(SW)}, 9);
        scan_dr(9, 9'b0);
        chk("bsr_upd_zero", 16'(dut.bsr_upd_q), 16'd0);

        // EXTEST with cleared latches, then reset in the middle of SHIFT_DR
        load_ir(4'b0010, 16'h0000);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("pre_rst_tdo0", 16'(JB_TDO), 16'd1);
        tick(1'b0, 1'b1);
        chk("pre_rst_tdo1", 16'(JB_TDO), 16'd0);
        tick(1'b0, 1'b1);
        chk("pre_rst_tdo2", 16'(JB_TDO), 16'd0);
        tick(1'b0, 1'b1);
        chk("pre_rst_tdo3", 16'(JB_TDO), 16'd1);
        JB_TRST_N = 1'b0;
        #1;
        chk("mid_rst_state", 16'(dut.u_tap.state_q), 16'(TEST_LOGIC_RESET));
        chk("mid_rst_tdo", 16'(JB_TDO), 16'd0);
        chk("mid_rst_led", LED, ref_led(SW));
        chk("mid_rst_ir", 16'(dut.ir_q), 16'(BYPASS));
        chk("mid_rst_bsr_sh", 16'(dut.bsr_sh_q), 16'd0);
        @(negedge JB_TCK);
        #1 JB_TRST_N = 1'b1;
        tick(1'b0, 1'b0);
        chk("post_rst_state", 16'(dut.u_tap.state_q), 16'(RUN_TEST_IDLE));

        chk("sb_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/onboard_top.md
# onboard_top

Board-level top that wraps a small 2-bit arithmetic core with a 9-cell IEEE 1149.1-style boundary-scan register (BSR). The BSR is controlled by a 16-state TAP controller on the JB header pins. Switches feed the core and LEDs show its result. Under EXTEST, the LED result pins are driven from the BSR update latches instead of the core.

## Interface
- No parameters. Widths are fixed constants in the package.
- JB_TCK, input, 1: sole clock for the TAP and the BSR. Rising and falling edges are both used.
- JB_TRST_N, input, 1: reset, asynchronous, active-low.
- JB_TMS, input, 1: TAP mode select, sampled on rising JB_TCK.
- JB_TDI, input, 1: serial data in, sampled on rising JB_TCK.
- JB_TDO, output, 1: serial data out, updated on falling JB_TCK.
- SW, input, 16: switches.
  - SW[15:14] = A.
  - SW[13:12] = B.
  - SW[11] = op.
  - SW[10:0] are unused.
- LED, output, 16: LED[15:12] carries the result. LED[11:0] is tied to 0.

## Operation
- Core is combinational and has no state.
  - op=1: result = A + B, zero-extended to 4 bits.
  - op=0: result = A * B, 4 bits.
  - Core inputs always come from SW. There is no INTEST.
- Internal 4-bit bus from_BSR_to_SYS is the value driven onto LED[15:12]. It must be visible by hierarchical reference.
  - It equals bsr_upd[3:0] when IR = EXTEST.
  - Otherwise it equals the core result.
- TAP: the standard 16 states (TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT/CAPTURE/SHIFT/EXIT1/PAUSE/EXIT2/UPDATE for both DR and IR), with standard TMS transitions.
  - Five consecutive TMS=1 cycles reach TEST_LOGIC_RESET from any state.
- IR: 4 bits. Opcodes:
  - BYPASS = 4'b1111.
  - SAMPLE_PRELOAD = 4'b0001.
  - EXTEST = 4'b0010.
  - Any other code selects BYPASS.
- IR shifting:
  - CAPTURE_IR loads 4'b0001.
  - SHIFT_IR shifts right: TDI enters bit 3, bit 0 goes to TDO. The first bit shifted becomes IR[0].
  - UPDATE_IR latches the shift stage into the active IR.
- BSR: 9 cells, bsr_sh[8:0] plus update latches bsr_upd[8:0].
  - Input cells: [8:7] = A, [6:5] = B, [4] = op.
  - Output cells: [3:0] = core result.
- BSR is the selected DR for SAMPLE_PRELOAD and EXTEST.
  - CAPTURE_DR loads {SW[15:11], core result}.
  - SHIFT_DR shifts right: TDI enters bit 8, bit 0 goes to TDO.
  - UPDATE_DR copies bsr_sh into bsr_upd.
- Bypass register: 1 bit, captures 0, shifts TDI to TDO.
- TDO outputs the IR LSB in SHIFT_IR and the selected DR LSB in SHIFT_DR. In all other states it outputs 0.

## Timing
- TAP state, shift stages, and capture all act on rising JB_TCK.
- Active IR and bsr_upd update on falling JB_TCK while in the UPDATE_IR / UPDATE_DR state.
- LED switches to bsr_upd on the falling edge that completes UPDATE_IR to EXTEST. There is no added latency.
- LED follows SW combinationally whenever EXTEST is not active.
- Reset (JB_TRST_N=0), asynchronous, takes effect immediately:
  - State = TEST_LOGIC_RESET.
  - IR = BYPASS.
  - bsr_sh = 0, bsr_upd = 0, TDO = 0.
  - LED shows the core result.
- Entering TEST_LOGIC_RESET through TMS has the same effect on IR; bsr_upd holds its value.
- Reset mid-shift discards the partial shift.
- After reset, one TCK with TMS=0 reaches RUN_TEST_IDLE.

## Structure
- Package onboard_pkg holds:
  - The TAP state enum.
  - IR width 4 and BSR width 9.
  - Opcode constants BYPASS, SAMPLE_PRELOAD, EXTEST.
- Sub-module tap_controller holds the TAP FSM.
  - Inputs: TCK, TRST_N, TMS.
  - Outputs: state, plus capture/shift/update strobes for IR and DR.
- IR, BSR, bypass, core, and muxes live in onboard_top.

## Test plan
- SW=16'b1001_1000_0000_0000 (A=2, B=1, op=1), idle TAP -> LED[15:12]=4'b0011 immediately.
- EXTEST sequence:
  - With the same SW, load IR by shifting 1,0,0,0 (SAMPLE_PRELOAD).
  - Shift DR bits 1,0,0,1,0,1,1,1,0 (last bit with TMS=1), then UPDATE_DR.
  - Load IR by shifting 0,1,0,0 (EXTEST).
  - Expect from_BSR_to_SYS = LED[15:12] = 4'b1001 within one TCK after UPDATE_IR.
- BYPASS: IR 1,1,1,1, then shift TDI pattern 1,0,1,1 -> TDO returns the same pattern one TCK later, with a 0 first.
- SAMPLE capture: A=3, B=3, op=0 -> shift 9 bits out -> TDO LSB-first 1,0,0,1,0,1,1,1,1 (9 = 1001, then op, B, A).
- From EXTEST, five TMS=1 cycles -> IR=BYPASS and LED returns to the core result.
- Assert JB_TRST_N low mid SHIFT_DR -> state TEST_LOGIC_RESET immediately, TDO=0, LED = core result.
